ransac_inlier_scorer: RTL and testbench

Consumes the per-point distance stream from the point-to-plane distance stage and scores each candidate plane by its inlier count. It sits directly downstream of the distance stage and upstream of the RANSAC controller. It counts inliers per batch, reports each plane's score, and tracks the best plane seen since the last clear.

---
 rtl/ransac_inlier_scorer_pkg.sv | 16 +
 rtl/ransac_inlier_scorer_if.sv | 29 ++
 rtl/ransac_best_plane_register.sv | 45 ++++
 rtl/ransac_inlier_scorer.sv | 74 +++++++
 tb/tb_ransac_inlier_scorer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/ransac_inlier_scorer_pkg.sv
// ransac_fixed: fixed-point distance/plane types plus inlier count, tie-break sum and scorer state types
package ransac_fixed;
    localparam int FIXED_BITS = 16;
    localparam int FIXED_VALUE_BITS = 16;
    localparam int COUNT_BITS = 16;
    typedef logic [FIXED_BITS-1:0] fixed_t;
    typedef struct packed {
        fixed_t nx;
        fixed_t ny;
        fixed_t nz;
        fixed_t d;
    } plane_t;
    typedef logic [COUNT_BITS-1:0] inlier_count_t;
    typedef logic [FIXED_VALUE_BITS+COUNT_BITS-1:0] inlier_sum_t;
    typedef enum logic {IDLE, ACCUM} scorer_state_t;
endpackage

// File: rtl/ransac_inlier_scorer_if.sv
// ransac_inlier_scorer_if: distance beats plus clear_best in (slave side), batch score and best plane out; best_sum only with RANSAC_INLIER_SUM_TIEBREAK_EN
interface ransac_inlier_scorer_if
    import ransac_fixed::*;
#(parameter int count_bits = COUNT_BITS) ();
    logic in_valid;
    logic in_first;
    logic in_last;
    fixed_t distance;
    plane_t plane;
    fixed_t threshold;
    logic clear_best;
    logic score_valid;
    logic [count_bits-1:0] score;
    logic best_valid;
    plane_t best_plane;
    logic [count_bits-1:0] best_count;
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
    logic [FIXED_VALUE_BITS+count_bits-1:0] best_sum;
    modport master (output in_valid, in_first, in_last, distance, plane, threshold, clear_best,
                    input score_valid, score, best_valid, best_plane, best_count, best_sum);
    modport slave (input in_valid, in_first, in_last, distance, plane, threshold, clear_best,
                   output score_valid, score, best_valid, best_plane, best_count, best_sum);
`else
    modport master (output in_valid, in_first, in_last, distance, plane, threshold, clear_best,
                    input score_valid, score, best_valid, best_plane, best_count);
    modport slave (input in_valid, in_first, in_last, distance, plane, threshold, clear_best,
                   output score_valid, score, best_valid, best_plane, best_count);
`endif
endinterface

// File: rtl/ransac_best_plane_register.sv
// ransac_best_plane_register: holds the best plane/count since clear_best, updated at batch close (clear applies first; smaller-sum tie-break with RANSAC_INLIER_SUM_TIEBREAK_EN)
module ransac_best_plane_register
    import ransac_fixed::*;
#(parameter int count_bits = COUNT_BITS) (
    input  logic clock,
    input  logic reset,
    input  logic clear_best,
    input  logic close,
    input  plane_t plane,
    input  logic [count_bits-1:0] count,
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
    input  logic [FIXED_VALUE_BITS+count_bits-1:0] sum,
    output logic [FIXED_VALUE_BITS+count_bits-1:0] best_sum,
`endif
    output logic best_valid,
    output plane_t best_plane,
    output logic [count_bits-1:0] best_count
);
    logic held, win;
    assign held = best_valid && !clear_best;
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
    assign win = !held || count > best_count || (count == best_count && sum < best_sum);
`else
    assign win = !held || count > best_count;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            best_valid <= 1'b0;
            best_plane <= '0;
            best_count <= '0;
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
            best_sum <= '0;
`endif
        end else if (close && win) begin
            best_valid <= 1'b1;
            best_plane <= plane;
            best_count <= count;
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
            best_sum <= sum;
`endif
        end else if (clear_best) begin
            best_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ransac_inlier_scorer.sv
// ransac_inlier_scorer: counts inliers per plane batch (clock/reset plain, stream and results on interface s), pulses score_valid, tracks best plane; option RANSAC_INLIER_SUM_TIEBREAK_EN
module ransac_inlier_scorer
    import ransac_fixed::*;
#(parameter int count_bits = COUNT_BITS) (
    input logic clock,
    input logic reset,
    ransac_inlier_scorer_if.slave s
);
    localparam logic [count_bits-1:0] CMAX = '1;
    scorer_state_t state, state_n;
    logic [count_bits-1:0] count, count_n;
    fixed_t thr_q, thr_eff;
    plane_t plane_q, plane_eff;
    logic start, close, hit;
    assign start = s.in_valid && (s.in_first || state == IDLE);
    assign close = s.in_valid && s.in_last;
    assign thr_eff = start ? s.threshold : thr_q;
    assign plane_eff = start ? s.plane : plane_q;
    assign hit = s.distance <= thr_eff;
    always_comb begin
        state_n = state;
        count_n = count;
        if (s.in_valid) begin
            state_n = s.in_last ? IDLE : ACCUM;
            count_n = start ? count_bits'(hit) : count + count_bits'(hit && count != CMAX);
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            thr_q <= '0;
            plane_q <= '0;
            s.score_valid <= 1'b0;
            s.score <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (start) begin
                thr_q <= s.threshold;
                plane_q <= s.plane;
            end
            s.score_valid <= close;
            if (close) s.score <= count_n;
        end
    end
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
    localparam int SW = FIXED_VALUE_BITS + count_bits;
    logic [SW-1:0] sum, sum_n, add;
    logic [SW:0] raw;
    assign add = hit ? SW'(s.distance) : '0;
    assign raw = (start ? {(SW+1){1'b0}} : {1'b0, sum}) + {1'b0, add};
    assign sum_n = !s.in_valid ? sum : raw[SW] ? '1 : raw[SW-1:0];
    always_ff @(posedge clock) begin
        if (reset) sum <= '0;
        else sum <= sum_n;
    end
`endif
    ransac_best_plane_register #(.count_bits(count_bits)) u_best (
        .clock(clock),
        .reset(reset),
        .clear_best(s.clear_best),
        .close(close),
        .plane(plane_eff),
        .count(count_n),
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
        .sum(sum_n),
        .best_sum(s.best_sum),
`endif
        .best_valid(s.best_valid),
        .best_plane(s.best_plane),
        .best_count(s.best_count)
    );
endmodule

// File: tb/tb_ransac_inlier_scorer.sv
// tb_ransac_inlier_scorer: directed and randomized checks of two scorer widths against a batch-level model
module tb_ransac_inlier_scorer;
    import ransac_fixed::*;
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
    localparam bit TIE = 1'b1;
`else
    localparam bit TIE = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    logic v = 0, f = 0, l = 0, c = 0;
    fixed_t d = '0, t = '0;
    plane_t p = '0;
    ransac_inlier_scorer_if #(.count_bits(16)) i16 ();
    ransac_inlier_scorer_if #(.count_bits(3)) i3 ();
    assign i16.in_valid = v;
    assign i16.in_first = f;
    assign i16.in_last = l;
    assign i16.distance = d;
    assign i16.plane = p;
    assign i16.threshold = t;
    assign i16.clear_best = c;
    assign i3.in_valid = v;
    assign i3.in_first = f;
    assign i3.in_last = l;
    assign i3.distance = d;
    assign i3.plane = p;
    assign i3.threshold = t;
    assign i3.clear_best = c;
    ransac_inlier_scorer #(.count_bits(16)) dut16 (.clock(clock), .reset(reset), .s(i16));
    ransac_inlier_scorer #(.count_bits(3)) dut3 (.clock(clock), .reset(reset), .s(i3));
    int cmax[2] = '{65535, 7};
    longint smax[2] = '{64'hFFFF_FFFF, 64'h7_FFFF};
    bit open[2];
    fixed_t mthr[2];
    plane_t mplane[2];
    int mcnt[2];
    longint msum[2];
    bit e_sv[2], e_bv[2];
    int e_score[2], e_bc[2];
    plane_t e_bp[2];
    longint e_bs[2];
    int n_cmp = 0, n_err = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            e_sv[k] = 1'b0;
            if (reset) begin
                open[k] = 0;
                mcnt[k] = 0;
                msum[k] = 0;
                e_score[k] = 0;
                e_bv[k] = 0;
                e_bc[k] = 0;
                e_bp[k] = '0;
                e_bs[k] = 0;
            end else begin
                if (c) e_bv[k] = 0;
                if (v) begin
                    if (f || !open[k]) begin
                        open[k] = 1;
                        mthr[k] = t;
                        mplane[k] = p;
                        mcnt[k] = 0;
                        msum[k] = 0;
                    end
                    if (d <= mthr[k]) begin
                        if (mcnt[k] < cmax[k]) mcnt[k]++;
                        msum[k] = (msum[k] + d > smax[k]) ? smax[k] : msum[k] + d;
                    end
                    if (l) begin
                        open[k] = 0;
                        e_sv[k] = 1;
                        e_score[k] = mcnt[k];
                        if (!e_bv[k] || mcnt[k] > e_bc[k] || (TIE && mcnt[k] == e_bc[k] && msum[k] < e_bs[k])) begin
                            e_bv[k] = 1;
                            e_bc[k] = mcnt[k];
                            e_bp[k] = mplane[k];
                            e_bs[k] = msum[k];
                        end
                    end
                end
            end
        end
    endtask
    task automatic check_all();
        check("score_valid16", i16.score_valid, e_sv[0]);
        check("score16", i16.score, e_score[0]);
        check("best_valid16", i16.best_valid, e_bv[0]);
        check("best_count16", i16.best_count, e_bc[0]);
        check("best_plane16", i16.best_plane, e_bp[0]);
        check("score_valid3", i3.score_valid, e_sv[1]);
        check("score3", i3.score, e_score[1]);
        check("best_valid3", i3.best_valid, e_bv[1]);
        check("best_count3", i3.best_count, e_bc[1]);
        check("best_plane3", i3.best_plane, e_bp[1]);
`ifdef RANSAC_INLIER_SUM_TIEBREAK_EN
        check("best_sum16", i16.best_sum, e_bs[0]);
        check("best_sum3", i3.best_sum, e_bs[1]);
`endif
    endtask
    task automatic cyc(input bit iv, input bit fi, input bit la, input fixed_t di, input fixed_t th,
                       input plane_t pl, input bit cl, input bit rs);
        v = iv;
        f = fi;
        l = la;
        d = di;
        t = th;
        p = pl;
        c = cl;
        reset = rs;
        model_step();
        @(negedge clock);
        check_all();
    endtask
    task automatic batch(input int n, input fixed_t di, input fixed_t th, input plane_t pl, input bit clr_last);
        for (int i = 0; i < n; i++) cyc(1, i == 0, i == n - 1, di, th, pl, clr_last && i == n - 1, 0);
    endtask
    plane_t pa, pb, pc, pd, pe, pf, pg, junk;
    initial begin
        pa = 64'h0100_0000_0000_0A00;
        pb = 64'h0000_0100_0000_0B00;
        pc = 64'h0000_0000_0100_0C00;
        pd = 64'h00B5_00B5_0000_0D00;
        pe = 64'h00B5_0000_00B5_0E00;
        pf = 64'h0000_00B5_00B5_0F00;
        pg = 64'h0093_0093_0093_1000;
        junk = 64'hDEAD_BEEF_CAFE_F00D;
        cyc(0, 0, 0, 0, 0, '0, 0, 1);
        cyc(0, 0, 0, 0, 0, '0, 0, 1);
        check("rst_score_valid", i16.score_valid, 0);
        check("rst_best_plane", i16.best_plane, 0);
        cyc(1, 1, 0, 16'h0080, 16'h0100, pa, 0, 0);
        cyc(1, 0, 0, 16'h0100, 16'h0000, junk, 0, 0);
        cyc(1, 0, 0, 16'h0180, 16'hFFFF, junk, 0, 0);
        cyc(1, 0, 0, 16'h0000, 16'h0000, junk, 0, 0);
        cyc(1, 0, 1, 16'h0200, 16'hFFFF, junk, 0, 0);
        check("tp1_score", i16.score, 3);
        check("tp1_best_valid", i16.best_valid, 1);
        check("tp1_best_count", i16.best_count, 3);
        check("tp1_best_plane", i16.best_plane, pa);
        cyc(0, 0, 0, 0, 0, '0, 1, 0);
        batch(3, 16'd100, 16'h0100, pa, 0);
        batch(3, 16'd0, 16'h0100, pb, 0);
        check("tp2_tie_plane", i16.best_plane, TIE ? pb : pa);
        batch(4, 16'd0, 16'h0100, pc, 0);
        check("tp2_win_plane", i16.best_plane, pc);
        check("tp2_win_count", i16.best_count, 4);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 16'd0, 16'h0100, pa, 0, 0);
            check("tp3_pulse", i16.score_valid, 1);
            check("tp3_score", i16.score, 1);
        end
        batch(7, 16'd0, 16'h0100, pd, 0);
        check("tp4_best7", i3.best_count, 7);
        batch(2, 16'd0, 16'h0100, pe, 1);
        check("tp4_clear_count", i16.best_count, 2);
        check("tp4_clear_valid", i16.best_valid, 1);
        check("tp4_clear_count3", i3.best_count, 2);
        cyc(1, 1, 0, 16'd0, 16'h0100, pa, 0, 0);
        cyc(1, 0, 0, 16'd0, 16'h0100, pa, 0, 0);
        cyc(1, 0, 1, 16'd0, 16'h0100, pa, 0, 1);
        check("tp5_no_score", i16.score_valid, 0);
        batch(2, 16'd0, 16'h0100, pf, 0);
        check("tp5_score", i16.score, 2);
        batch(10, 16'd0, 16'h0100, pg, 0);
        check("tp6_sat", i3.score, 7);
        check("tp6_wide", i16.score, 10);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                fixed_t'($urandom_range(0, 600)), fixed_t'($urandom_range(0, 512)),
                plane_t'({$urandom(), $urandom()}), $urandom_range(0, 40) == 0, $urandom_range(0, 200) == 0);
        cyc(0, 0, 0, 0, 0, '0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
